uart_rx_fifo_ctrl: RTL

Memory-mapped receive buffer sitting directly downstream of the UART receiver. It captures each received byte on the receiver's RX_status pulse into a small FIFO. The pipeline CPU's MEM stage reads bytes and status through two peripheral registers, and the block raises an interrupt while data is pending. It decouples byte arrival from CPU polling latency and reports overruns.

---
 rtl/uart_rx_fifo_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/uart_rx_fifo_ctrl.sv
// Receive-side byte FIFO between the UART receiver and the CPU MEM stage.
// Captures a byte on each rising RX_status and exposes data/status registers.
module uart_rx_fifo_ctrl #(
  parameter int          DEPTH    = 16,
  parameter int          PTR_W    = 4,
  parameter logic [31:0] RXD_ADDR = 32'h4000_0018,
  parameter logic [31:0] CON_ADDR = 32'h4000_0020
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [7:0]  RX_data,
  input  logic        RX_status,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        irq
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [7:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             overflow;
  logic             irq_en;
  logic             prev_status;
  logic             irq_q;

  logic       push;
  logic       pop;
  logic       full;
  logic       valid;
  logic       do_write;
  logic       set_ovf;
  logic       con_write;
  logic [8:0] count9;
  logic       unused_bits;

  assign full      = (count == FULL_COUNT);
  assign valid     = (count != '0);
  assign push      = RX_status & ~prev_status & ~reset;
  assign pop       = MemRead & (Address == RXD_ADDR) & valid;
  // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
  assign do_write  = push & (~full | pop);
  assign set_ovf   = push & full & ~pop;
  assign con_write = MemWrite & (Address == CON_ADDR);
  assign count9    = 9'(count);
  assign irq       = irq_q;

  assign unused_bits = ^{WriteData[31:4], WriteData[1:0]};

  always_ff @(posedge sys_clk) begin
    prev_status <= RX_status;
  end

  always_ff @(posedge sys_clk) begin
    if (do_write) begin
      mem[wr_ptr] <= RX_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      irq_en   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_write && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !do_write) begin
        count <= count - 1'b1;
      end
      if (con_write) begin
        irq_en <= WriteData[3];
      end
      // Set beats a clear requested in the same cycle.
      if (set_ovf) begin
        overflow <= 1'b1;
      end else if (con_write && WriteData[2]) begin
        overflow <= 1'b0;
      end
      irq_q <= irq_en & valid;
    end
  end

  always_comb begin
    ReadData = 32'h0;
    if (MemRead) begin
      if (Address == RXD_ADDR) begin
        if (valid) begin
          ReadData = {24'h0, mem[rd_ptr]};
        end
      end else if (Address == CON_ADDR) begin
        ReadData = {19'h0, count9, irq_en, overflow, full, valid};
      end
    end
  end

endmodule
